// File: rtl/key_input_pkg.sv
// Shared definitions for the board-key input path: repeat FSM states and
// default 50 MHz timing constants.
package key_input_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DAS  = 2'd1,
    ARR  = 2'd2
  } repeat_state_e;

  localparam int unsigned CLK_HZ        = 50_000_000;
  localparam int unsigned DEBOUNCE_20MS = 1_000_000;
  localparam int unsigned DAS_267MS     = 13_350_000;
  localparam int unsigned ARR_50MS      = 2_500_000;

endpackage

// File: rtl/key_debounce_repeat_if.sv
// Key path bundle between the synchronizer/game side (master) and one
// key_debounce_repeat instance (slave).
interface key_debounce_repeat_if;
  import key_input_pkg::*;

  // Level/strobe signalling, no handshake: key_sync and repeat_en are sampled
  // every clock; all outputs are registered and each pulse is high for one cycle.
  logic          key_sync;
  logic          repeat_en;
  logic          key_level;
  logic          press_pulse;
  logic          release_pulse;
  logic          move_pulse;
  repeat_state_e state;

  modport master (
    output key_sync, repeat_en,
    input  key_level, press_pulse, release_pulse, move_pulse, state
  );

  modport slave (
    input  key_sync, repeat_en,
    output key_level, press_pulse, release_pulse, move_pulse, state
  );

endinterface

// File: rtl/debounce_filter.sv
// Stable-count debouncer: the level flips only after STABLE_CYCLES
// consecutive samples disagreeing with it.
module debounce_filter #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic key_sync,
  output logic level,
  output logic rise,
  output logic fall,
  output logic rise_next,
  output logic fall_next
);

  logic [CNT_W-1:0] cnt;
  logic             differ;
  logic             hit;

  assign differ = (key_sync != level);
  assign hit    = differ && (cnt == CNT_W'(STABLE_CYCLES - 1));

  // Exported so the repeat logic can register its move pulse on the same edge.
  assign rise_next = hit && !level;
  assign fall_next = hit && level;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= rise_next;
      fall <= fall_next;
      if (!differ) begin
        cnt <= '0;
      end else if (hit) begin
        level <= ~level;
        cnt   <= '0;
      end else if (cnt != '1) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_debounce_repeat.sv
// Debounced key with press/release strobes and delayed-auto-shift repeat
// move pulses for held keys.
module key_debounce_repeat
  import key_input_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEBOUNCE_20MS,
  parameter int unsigned DAS_CYCLES    = DAS_267MS,
  parameter int unsigned ARR_CYCLES    = ARR_50MS,
  parameter int unsigned CNT_W         = 24
) (
  input logic                  clock,
  input logic                  reset,
  key_debounce_repeat_if.slave bus
);

  localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  if (STABLE_CYCLES < 2 || DAS_CYCLES < 2 || ARR_CYCLES < 2 ||
      64'(STABLE_CYCLES) > CNT_MAX || 64'(DAS_CYCLES) > CNT_MAX ||
      64'(ARR_CYCLES) > CNT_MAX) begin : g_bad_params
    $error("key_debounce_repeat: timing parameter below 2 or wider than CNT_W");
  end

  localparam logic [CNT_W-1:0] DAS_LAST = CNT_W'(DAS_CYCLES - 1);
  localparam logic [CNT_W-1:0] ARR_LAST = CNT_W'(ARR_CYCLES - 1);

  logic             level;
  logic             rise;
  logic             fall;
  logic             rise_next;
  logic             fall_next;
  logic             move_q;
  logic [CNT_W-1:0] rcnt;
  repeat_state_e    state;

  debounce_filter #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_filter (
    .clock    (clock),
    .reset    (reset),
    .key_sync (bus.key_sync),
    .level    (level),
    .rise     (rise),
    .fall     (fall),
    .rise_next(rise_next),
    .fall_next(fall_next)
  );

  // Release takes priority so a repeat tick never lands on the release edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      rcnt   <= '0;
      move_q <= 1'b0;
    end else begin
      move_q <= 1'b0;
      if (fall_next) begin
        state <= IDLE;
        rcnt  <= '0;
      end else if (rise_next) begin
        state  <= DAS;
        rcnt   <= '0;
        move_q <= 1'b1;
      end else begin
        case (state)
          IDLE: rcnt <= '0;
          DAS: begin
            if (rcnt == DAS_LAST) begin
              if (bus.repeat_en) begin
                move_q <= 1'b1;
                rcnt   <= '0;
                state  <= ARR;
              end
            end else if (rcnt != '1) begin
              rcnt <= rcnt + 1'b1;
            end
          end
          ARR: begin
            // With repeat disabled the count freezes and resumes later.
            if (bus.repeat_en) begin
              if (rcnt == ARR_LAST) begin
                move_q <= 1'b1;
                rcnt   <= '0;
              end else if (rcnt != '1) begin
                rcnt <= rcnt + 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
            rcnt  <= '0;
          end
        endcase
      end
    end
  end

  assign bus.key_level     = level;
  assign bus.press_pulse   = rise;
  assign bus.release_pulse = fall;
  assign bus.move_pulse    = move_q;
  assign bus.state         = state;

endmodule
